// File: rtl/pong_pkg.sv
// Shared definitions for the pong core: control-source encoding and the
// paddle idle position, plus the raw source selection used by the paddle path.
package pong_pkg;

    typedef enum logic [1:0] {
        PM_Y      = 2'd0,
        PM_X      = 2'd1,
        PM_INVX   = 2'd2,
        PM_PADDLE = 2'd3
    } paddle_mode_e;

    localparam logic [7:0] PADDLE_CENTER = 8'h80;

    // Signed stick axes are re-biased to unsigned by flipping the sign bit;
    // XOR with 7F both re-biases and mirrors the X axis.
    function automatic logic [7:0] raw_select(
        input paddle_mode_e mode,
        input logic [15:0]  analog,
        input logic [7:0]   paddle
    );
        logic [7:0] r;
        case (mode)
            PM_Y:    r = analog[15:8] + 8'h80;
            PM_X:    r = analog[7:0] + 8'h80;
            PM_INVX: r = analog[7:0] ^ 8'h7F;
            default: r = paddle;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/paddle_ema.sv
// Rate-limited exponential smoother: acc tracks raw scaled by 2^SHIFT and
// moves 1/2^SHIFT of the error per strobe; snap reloads it instantly.
module paddle_ema #(
    parameter int         SHIFT  = 2,
    parameter logic [7:0] CENTER = 8'h80
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       strobe,
    input  logic       snap,
    input  logic [7:0] raw,
    output logic [7:0] filt
);

    localparam int W = 8 + SHIFT;
    localparam logic [W-1:0] ACC_RST = W'(CENTER) << SHIFT;

    logic [W-1:0] acc_reg;
    logic [W-1:0] acc_next;
    logic [W-1:0] upd;

    // The intermediate acc+raw may wrap, but the final value is bounded by
    // 255<<SHIFT, so modulo-2^W arithmetic yields the exact result.
    assign upd = acc_reg + W'(raw) - (acc_reg >> SHIFT);

    always_comb begin
        acc_next = acc_reg;
        if (snap)
            acc_next = W'(raw) << SHIFT;
        else if (strobe)
            acc_next = upd;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            acc_reg <= ACC_RST;
        else
            acc_reg <= acc_next;
    end

    assign filt = acc_reg[W-1:SHIFT];

endmodule

// File: rtl/paddle_conditioner.sv
// Per-player paddle path: source select, ~1 kHz smoothing, and a frame latch
// so the paddle position only changes at the start of vertical blank.
module paddle_conditioner
    import pong_pkg::*;
#(
    parameter int         SHIFT  = 2,
    parameter int         DIV    = 7159,
    parameter logic [7:0] CENTER = PADDLE_CENTER
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  paddle_mode_e mode,
    input  logic [15:0]  analog,
    input  logic [7:0]   paddle,
    input  logic         vblank,
    output logic [7:0]   vpos,
    output logic         frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [7:0]    raw_reg;
    paddle_mode_e  mode_reg;
    logic          snap_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          vb_d_reg;
    logic          strobe;
    logic          vb_rise;
    logic [7:0]    filt;

    assign strobe   = (cnt_reg == CNT_MAX);
    assign cnt_next = strobe ? '0 : cnt_reg + 1'b1;
    assign vb_rise  = vblank & ~vb_d_reg;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            raw_reg    <= CENTER;
            mode_reg   <= PM_Y;
            snap_reg   <= 1'b0;
            cnt_reg    <= '0;
            vb_d_reg   <= 1'b0;
            vpos       <= CENTER;
            frame_tick <= 1'b0;
        end else begin
            raw_reg    <= raw_select(mode, analog, paddle);
            mode_reg   <= mode;
            // A source switch jumps straight to the new source instead of
            // slewing across the screen.
            snap_reg   <= (mode != mode_reg);
            cnt_reg    <= cnt_next;
            vb_d_reg   <= vblank;
            frame_tick <= vb_rise;
            if (vb_rise)
                vpos <= filt;
        end
    end

    paddle_ema #(
        .SHIFT  (SHIFT),
        .CENTER (CENTER)
    ) u_ema (
        .clk_sys (clk_sys),
        .reset   (reset),
        .strobe  (strobe),
        .snap    (snap_reg),
        .raw     (raw_reg),
        .filt    (filt)
    );

endmodule

// File: tb/tb_paddle_conditioner.sv
// Bench for paddle_conditioner: a SHIFT=2/DIV=4 and a SHIFT=0/DIV=1 instance
// share stimulus; an integer model is compared every cycle plus literal pins.
module tb_paddle_conditioner;
    import pong_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    paddle_mode_e mode = PM_Y;
    logic [15:0]  analog = 16'h4000;
    logic [7:0]   paddle = 8'h00;
    logic         vblank = 1'b0;
    logic [7:0]   vpos2, vpos0;
    logic         tick2, tick0;

    int checks = 0;
    int errors = 0;
    bit done = 0;

    always #5 clk = ~clk;

    paddle_conditioner #(.SHIFT(2), .DIV(4), .CENTER(8'h80)) dut (
        .clk_sys(clk), .reset(reset), .mode(mode), .analog(analog),
        .paddle(paddle), .vblank(vblank), .vpos(vpos2), .frame_tick(tick2)
    );

    paddle_conditioner #(.SHIFT(0), .DIV(1), .CENTER(8'h80)) dut0 (
        .clk_sys(clk), .reset(reset), .mode(mode), .analog(analog),
        .paddle(paddle), .vblank(vblank), .vpos(vpos0), .frame_tick(tick0)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int raw; int mode; int snap; int cnt;
        int acc; int vpos; int tick; int vb_d;
    } mstate_t;

    function automatic mstate_t mreset(input int shift);
        mstate_t s;
        s.raw = 128; s.mode = 0; s.snap = 0; s.cnt = 0;
        s.acc = 128 << shift; s.vpos = 128; s.tick = 0; s.vb_d = 0;
        return s;
    endfunction

    function automatic int msel(input int md, input int an, input int pd);
        case (md)
            0: return (((an >> 8) & 255) + 128) % 256;
            1: return ((an & 255) + 128) % 256;
            2: return (an & 255) ^ 127;
            default: return pd;
        endcase
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int shift, input int div,
                                      input int md, input int an, input int pd, input int vb);
        mstate_t n = s;
        int scale = 1 << shift;
        n.raw  = msel(md, an, pd);
        n.mode = md;
        n.snap = (md != s.mode) ? 1 : 0;
        n.cnt  = (s.cnt == div - 1) ? 0 : s.cnt + 1;
        if (s.snap != 0)
            n.acc = s.raw * scale;
        else if (s.cnt == div - 1)
            n.acc = s.acc + s.raw - s.acc / scale;
        n.vb_d = vb;
        n.tick = (vb != 0 && s.vb_d == 0) ? 1 : 0;
        if (n.tick != 0)
            n.vpos = s.acc / scale;
        return n;
    endfunction

    mstate_t m2, m0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m2 <= mreset(2);
            m0 <= mreset(0);
        end else begin
            m2 <= mstep(m2, 2, 4, int'(mode), int'(analog), int'(paddle), int'(vblank));
            m0 <= mstep(m0, 0, 1, int'(mode), int'(analog), int'(paddle), int'(vblank));
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("model_vpos2", int'(vpos2), m2.vpos);
            check("model_tick2", int'(tick2), m2.tick);
            check("model_acc2",  int'(dut.u_ema.acc_reg), m2.acc);
            check("model_vpos0", int'(vpos0), m0.vpos);
            check("model_tick0", int'(tick0), m0.tick);
            check("model_acc0",  int'(dut0.u_ema.acc_reg), m0.acc);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] invx_in  [3] = '{8'h00, 8'h7F, 8'h80};
    logic [7:0] invx_exp [3] = '{8'h7F, 8'h00, 8'hFF};

    initial begin
        int ticks;
        int i;
        repeat (3) @(negedge clk);
        check("rst_vpos", int'(vpos2), 'h80);
        check("rst_acc",  int'(dut.u_ema.acc_reg), 'h200);
        check("rst_tick", int'(tick2), 0);

        // Release with PM_Y / raw C0 and an immediate vblank rise.
        reset = 1'b0;
        vblank = 1'b1;
        @(negedge clk);
        $display("txn vblank_rise_after_reset vpos=%0h tick=%0d", vpos2, tick2);
        check("first_latch_vpos", int'(vpos2), 'h80);
        check("first_latch_tick", int'(tick2), 1);
        @(negedge clk);
        check("tick_one_cycle", int'(tick2), 0);
        vblank = 1'b0;
        @(negedge clk);
        check("pre_strobe_acc", int'(dut.u_ema.acc_reg), 'h200);
        @(negedge clk);
        $display("txn first_strobe acc=%0h", dut.u_ema.acc_reg);
        check("strobe1_acc", int'(dut.u_ema.acc_reg), 'h240);
        check("strobe1_filt", int'(dut.u_ema.filt), 'h90);
        repeat (4) @(negedge clk);
        $display("txn second_strobe acc=%0h", dut.u_ema.acc_reg);
        check("strobe2_acc", int'(dut.u_ema.acc_reg), 'h270);
        check("strobe2_filt", int'(dut.u_ema.filt), 'h9C);
        repeat (200) @(negedge clk);
        check("converged_acc", int'(dut.u_ema.acc_reg), 'h300);
        vblank = 1'b1;
        @(negedge clk);
        $display("txn converged_latch vpos=%0h", vpos2);
        check("converged_vpos", int'(vpos2), 'hC0);
        vblank = 1'b0;

        // Inverted X and plain X on the unfiltered instance.
        mode = PM_INVX;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) analog = {8'h00, invx_in[k]};
            else begin mode = PM_X; analog = 16'h0040; end
            repeat (4) @(negedge clk);
            check("src_acc0", int'(dut0.u_ema.acc_reg), (k < 3) ? int'(invx_exp[k]) : 'hC0);
            vblank = 1'b1;
            @(negedge clk);
            $display("txn source k=%0d analog=%0h vpos0=%0h", k, analog, vpos0);
            check("src_vpos0", int'(vpos0), (k < 3) ? int'(invx_exp[k]) : 'hC0);
            vblank = 1'b0;
            @(negedge clk);
        end

        // Mid-filter switch to the spinner, snap landing on a strobe cycle.
        mode = PM_Y;
        analog = 16'h4000;
        repeat (6) @(negedge clk);
        for (i = 0; i < 8 && dut.cnt_reg != 2'd2; i++) @(negedge clk);
        check("align_cnt2", int'(dut.cnt_reg), 2);
        paddle = 8'h10;
        mode = PM_PADDLE;
        repeat (2) @(negedge clk);
        $display("txn snap_to_paddle acc=%0h", dut.u_ema.acc_reg);
        check("snap_acc", int'(dut.u_ema.acc_reg), 'h40);
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        check("snap_vpos", int'(vpos2), 'h10);
        vblank = 1'b0;

        // vblank rise coinciding with a strobe latches the pre-strobe value.
        for (i = 0; i < 8 && dut.cnt_reg != 2'd0; i++) @(negedge clk);
        check("align_cnt0", int'(dut.cnt_reg), 0);
        paddle = 8'hF0;
        repeat (4) @(negedge clk);
        check("slew1_acc", int'(dut.u_ema.acc_reg), 'h120);
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        $display("txn vblank_on_strobe vpos=%0h acc=%0h", vpos2, dut.u_ema.acc_reg);
        check("coincide_vpos", int'(vpos2), 'h48);
        check("coincide_acc", int'(dut.u_ema.acc_reg), 'h1C8);
        ticks = int'(tick2);
        repeat (60) begin
            @(negedge clk);
            ticks += int'(tick2);
        end
        $display("txn held_vblank ticks=%0d", ticks);
        check("held_ticks", ticks, 1);
        check("held_vpos", int'(vpos2), 'h48);
        vblank = 1'b0;

        // Asynchronous reset between edges while still converging.
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        mode = PM_Y;
        analog = 16'h4000;
        reset = 1'b1;
        #1;
        $display("txn async_reset vpos=%0h acc=%0h", vpos2, dut.u_ema.acc_reg);
        check("areset_vpos", int'(vpos2), 'h80);
        check("areset_acc", int'(dut.u_ema.acc_reg), 'h200);
        @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_strobe", int'(dut.u_ema.acc_reg), 'h200);
        @(posedge clk);
        #1;
        $display("txn post_reset_strobe acc=%0h", dut.u_ema.acc_reg);
        check("post_rst_strobe", int'(dut.u_ema.acc_reg), 'h240);

        repeat (2) @(negedge clk);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
